usb_hid_ctrl: RTL and testbench

Controller that sequences and supervises the low-speed USB HID host core, and turns its raw report outputs into CPU-friendly data. It drives the host core's reset, detects connection loss and protocol errors and retries, and diffs successive keyboard reports into a press/release event FIFO. It also accumulates mouse motion until the CPU reads it. It sits between the HID host core and the SoC peripheral register block, all in the 12 MHz USB clock domain.

---
 rtl/usb_hid_ctrl_if.sv | 44 ++++
 rtl/usb_hid_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_usb_hid_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_hid_ctrl_if.sv
// rtl/usb_hid_ctrl_if.sv - HID host-core and CPU-side signal bundle for usb_hid_ctrl
`timescale 1ns/1ps
interface usb_hid_ctrl_if #(parameter int FIFO_DEPTH = 16) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          host_rst_n;
  logic [1:0]    typ;
  logic          reportPulse;
  logic          conerr;
  logic [7:0]    key_modifiers;
  logic [7:0]    key1;
  logic [7:0]    key2;
  logic [7:0]    key3;
  logic [7:0]    key4;
  logic [7:0]    mouse_btn;
  logic [7:0]    mouse_dx;
  logic [7:0]    mouse_dy;
  logic          evt_rd;
  logic          evt_valid;
  logic [9:0]    evt_data;
  logic [CW-1:0] evt_count;
  logic          evt_overflow;
  logic          ovf_clr;
  logic          mouse_rd;
  logic [15:0]   mouse_x;
  logic [15:0]   mouse_y;
  logic [2:0]    mouse_buttons;
  logic [1:0]    link_state;
  logic [7:0]    retry_cnt;

  modport master (
    output typ, reportPulse, conerr, key_modifiers, key1, key2, key3, key4,
           mouse_btn, mouse_dx, mouse_dy, evt_rd, ovf_clr, mouse_rd,
    input  host_rst_n, evt_valid, evt_data, evt_count, evt_overflow,
           mouse_x, mouse_y, mouse_buttons, link_state, retry_cnt
  );

  modport slave (
    input  typ, reportPulse, conerr, key_modifiers, key1, key2, key3, key4,
           mouse_btn, mouse_dx, mouse_dy, evt_rd, ovf_clr, mouse_rd,
    output host_rst_n, evt_valid, evt_data, evt_count, evt_overflow,
           mouse_x, mouse_y, mouse_buttons, link_state, retry_cnt
  );
endinterface

// File: rtl/usb_hid_ctrl.sv
// rtl/usb_hid_ctrl.sv - link supervisor, keyboard diff engine, event FIFO and mouse accumulator for the HID host core
`timescale 1ns/1ps
module usb_hid_ctrl #(
  parameter int RST_CYCLES   = 12000,
  parameter int CONN_TIMEOUT = 12000000,
  parameter int ERR_CYCLES   = 1200,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic          usbclk,
  input  logic          usbrst,
  usb_hid_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
  localparam logic [31:0] CONN_LAST = 32'(CONN_TIMEOUT - 1);
  localparam logic [31:0] ERR_LAST  = 32'(ERR_CYCLES - 1);

  typedef enum logic [1:0] {HOLD = 2'd0, WAIT = 2'd1, RUN = 2'd2} link_t;

  link_t       state;
  logic [31:0] cyc;
  logic [31:0] errc;
  logic        host_rst_n_q;
  logic [7:0]  retry_q;

  logic        pend_v;
  logic [7:0]  pend_mod;
  logic [31:0] pend_keys;
  logic        flush_req;
  logic        busy;
  logic        eng_flush;
  logic [3:0]  step;
  logic [31:0] prev_keys;
  logic [31:0] cur_keys;
  logic [7:0]  prev_mod;
  logic [7:0]  cur_mod;

  logic [7:0]  cand_key;
  logic        cand_hit;
  logic        cand_push;
  logic [9:0]  cand_data;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;

  logic [15:0] mx;
  logic [15:0] my;
  logic [2:0]  mbtn;

  logic disc, flushing, err_trip, to_hold, rollover, kbd_acc, mouse_acc;
  logic full, pop, push_ok, drop;
  logic unused_btn;

  assign disc      = (state == RUN) && (bus.typ == 2'd0);
  assign flushing  = flush_req || (busy && eng_flush);
  assign err_trip  = bus.conerr && (errc == ERR_LAST);
  // A running disconnect flush must finish before the core is reset again.
  assign to_hold   = (state != HOLD) && !flushing && !disc &&
                     (err_trip || ((state == WAIT) && (bus.typ == 2'd0) && (cyc == CONN_LAST)));
  assign rollover  = (bus.key1 == 8'h01) || (bus.key2 == 8'h01) ||
                     (bus.key3 == 8'h01) || (bus.key4 == 8'h01);
  assign kbd_acc   = (state == RUN) && bus.reportPulse && (bus.typ == 2'd1) && !rollover;
  assign mouse_acc = (state == RUN) && bus.reportPulse && (bus.typ == 2'd2);
  assign unused_btn = ^bus.mouse_btn[7:3];

  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      state        <= HOLD;
      cyc          <= '0;
      errc         <= '0;
      host_rst_n_q <= 1'b0;
      retry_q      <= '0;
    end else begin
      if ((state == HOLD) || !bus.conerr) errc <= '0;
      else if (!err_trip)                 errc <= errc + 32'd1;

      if (to_hold) begin
        state        <= HOLD;
        cyc          <= '0;
        host_rst_n_q <= 1'b0;
        if (retry_q != 8'hff) retry_q <= retry_q + 8'd1;
      end else begin
        case (state)
          HOLD: begin
            if (cyc == RST_LAST) begin
              state        <= WAIT;
              cyc          <= '0;
              host_rst_n_q <= 1'b1;
            end else begin
              cyc <= cyc + 32'd1;
            end
          end
          WAIT: begin
            if (bus.typ != 2'd0) begin
              state <= RUN;
              cyc   <= '0;
            end else if (cyc != CONN_LAST) begin
              cyc <= cyc + 32'd1;
            end
          end
          RUN: begin
            if (disc) begin
              state <= WAIT;
              cyc   <= '0;
            end
          end
          default: state <= HOLD;
        endcase
      end
    end
  end

  // Steps 0-3 release candidates, 4-7 press candidates, 8 the modifier byte.
  always_comb begin
    cand_key  = 8'h00;
    cand_hit  = 1'b0;
    cand_push = 1'b0;
    cand_data = 10'h000;
    if (busy) begin
      if (step < 4'd4) begin
        cand_key = prev_keys[{step[1:0], 3'b000} +: 8];
        for (int i = 0; i < 4; i++)
          if (cur_keys[8*i +: 8] == cand_key) cand_hit = 1'b1;
        cand_push = (cand_key != 8'h00) && !cand_hit;
        cand_data = {2'b00, cand_key};
      end else if (step < 4'd8) begin
        cand_key = cur_keys[{step[1:0], 3'b000} +: 8];
        for (int i = 0; i < 4; i++)
          if (prev_keys[8*i +: 8] == cand_key) cand_hit = 1'b1;
        cand_push = (cand_key != 8'h00) && !cand_hit;
        cand_data = {2'b01, cand_key};
      end else begin
        cand_push = (cur_mod != prev_mod);
        cand_data = {2'b11, cur_mod};
      end
    end
  end

  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      pend_v    <= 1'b0;
      pend_mod  <= '0;
      pend_keys <= '0;
      flush_req <= 1'b0;
      busy      <= 1'b0;
      eng_flush <= 1'b0;
      step      <= '0;
      prev_keys <= '0;
      cur_keys  <= '0;
      prev_mod  <= '0;
      cur_mod   <= '0;
    end else begin
      if (busy) begin
        if (step == 4'd8) begin
          busy      <= 1'b0;
          prev_keys <= cur_keys;
          prev_mod  <= cur_mod;
        end
        step <= step + 4'd1;
      end else if (flush_req) begin
        busy      <= 1'b1;
        eng_flush <= 1'b1;
        step      <= '0;
        cur_keys  <= '0;
        cur_mod   <= '0;
        flush_req <= 1'b0;
      end else if (pend_v) begin
        busy      <= 1'b1;
        eng_flush <= 1'b0;
        step      <= '0;
        cur_keys  <= pend_keys;
        cur_mod   <= pend_mod;
        pend_v    <= 1'b0;
      end

      if (disc) begin
        flush_req <= 1'b1;
        pend_v    <= 1'b0;
      end else if (kbd_acc) begin
        pend_v    <= 1'b1;
        pend_mod  <= bus.key_modifiers;
        pend_keys <= {bus.key4, bus.key3, bus.key2, bus.key1};
      end
    end
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = bus.evt_rd && (count != '0);
  assign push_ok = cand_push && (!full || pop);
  assign drop    = cand_push && full && !pop;

  always_ff @(posedge usbclk) begin
    if (push_ok) mem[wr_ptr] <= cand_data;
  end

  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      if (drop)             ovf <= 1'b1;
      else if (bus.ovf_clr) ovf <= 1'b0;
    end
  end

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [7:0] d);
    logic [16:0] s;
    s = {a[15], a} + {{9{d[7]}}, d};
    if (s[16] != s[15]) sat_add = s[16] ? 16'h8000 : 16'h7fff;
    else                sat_add = s[15:0];
  endfunction

  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      mx   <= '0;
      my   <= '0;
      mbtn <= '0;
    end else if (mouse_acc) begin
      mx   <= sat_add(bus.mouse_rd ? 16'h0000 : mx, bus.mouse_dx);
      my   <= sat_add(bus.mouse_rd ? 16'h0000 : my, bus.mouse_dy);
      mbtn <= bus.mouse_btn[2:0];
    end else if (bus.mouse_rd) begin
      mx <= '0;
      my <= '0;
    end
  end

  assign bus.host_rst_n    = host_rst_n_q;
  assign bus.link_state    = state;
  assign bus.retry_cnt     = retry_q;
  assign bus.evt_valid     = (count != '0);
  assign bus.evt_data      = (count != '0) ? mem[rd_ptr] : 10'h000;
  assign bus.evt_count     = count;
  assign bus.evt_overflow  = ovf;
  assign bus.mouse_x       = mx;
  assign bus.mouse_y       = my;
  assign bus.mouse_buttons = mbtn;
endmodule

// File: tb/tb_usb_hid_ctrl.sv
// tb/tb_usb_hid_ctrl.sv - randomized self-checking bench for usb_hid_ctrl
`timescale 1ns/1ps
module tb_usb_hid_ctrl;
  localparam int DEPTH = 16;
  localparam int RSTC  = 12000;
  localparam int TMO   = 3000;
  localparam int ERRC  = 1200;

  logic usbclk;
  logic usbrst;
  int   total = 0;
  int   bad   = 0;

  logic [9:0]  exp_q[$];
  logic        m_ovf;
  logic [31:0] m_prev;
  logic [7:0]  m_pmod;
  int          mx, my;
  logic [2:0]  mbtn;
  int          m_retry;

  usb_hid_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();

  usb_hid_ctrl #(.RST_CYCLES(RSTC), .CONN_TIMEOUT(TMO), .ERR_CYCLES(ERRC), .FIFO_DEPTH(DEPTH)) dut (
    .usbclk(usbclk),
    .usbrst(usbrst),
    .bus   (bus)
  );

  initial usbclk = 1'b0;
  always #5 usbclk = ~usbclk;

  task automatic model_push(input logic [9:0] e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else m_ovf = 1'b1;
  endtask

  // Expected events of one keyboard report, straight from the press/release rules.
  task automatic model_report(input logic [7:0] mod, input logic [31:0] keys);
    bit roll = 0;
    bit found;
    for (int i = 0; i < 4; i++) if (keys[8*i +: 8] == 8'h01) roll = 1;
    if (roll) return;
    for (int i = 0; i < 4; i++) begin
      found = 0;
      for (int j = 0; j < 4; j++) if (keys[8*j +: 8] == m_prev[8*i +: 8]) found = 1;
      if (m_prev[8*i +: 8] != 0 && !found) model_push({2'b00, m_prev[8*i +: 8]});
    end
    for (int i = 0; i < 4; i++) begin
      found = 0;
      for (int j = 0; j < 4; j++) if (m_prev[8*j +: 8] == keys[8*i +: 8]) found = 1;
      if (keys[8*i +: 8] != 0 && !found) model_push({2'b01, keys[8*i +: 8]});
    end
    if (mod != m_pmod) model_push({2'b11, mod});
    m_prev = keys;
    m_pmod = mod;
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic pulse_kbd(input logic [7:0] mod, input logic [31:0] keys);
    @(negedge usbclk);
    bus.key_modifiers = mod;
    {bus.key4, bus.key3, bus.key2, bus.key1} = keys;
    bus.reportPulse = 1'b1;
    @(negedge usbclk);
    bus.reportPulse = 1'b0;
    model_report(mod, keys);
  endtask

  task automatic send_kbd(input logic [7:0] mod, input logic [31:0] keys);
    pulse_kbd(mod, keys);
    repeat (11) @(negedge usbclk);
  endtask

  task automatic drain(input string tag);
    total++;
    if (bus.evt_count !== 5'(exp_q.size())) begin
      bad++; $display("FAIL %s_count got=%0d exp=%0d", tag, bus.evt_count, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      total++;
      if (bus.evt_valid !== 1'b1 || bus.evt_data !== exp_q[0]) begin
        bad++; $display("FAIL %s_event got=%h/%b exp=%h", tag, bus.evt_data, bus.evt_valid, exp_q[0]);
      end
      bus.evt_rd = 1'b1;
      @(negedge usbclk);
      bus.evt_rd = 1'b0;
      void'(exp_q.pop_front());
    end
    total++;
    if (bus.evt_valid !== 1'b0) begin
      bad++; $display("FAIL %s_empty got=%b exp=0", tag, bus.evt_valid);
    end
  endtask

  task automatic send_mouse(input logic [7:0] dx, input logic [7:0] dy, input logic [7:0] btn,
                            input bit rd, input bit rep);
    int base_x, base_y;
    @(negedge usbclk);
    bus.mouse_dx = dx; bus.mouse_dy = dy; bus.mouse_btn = btn;
    bus.reportPulse = rep; bus.mouse_rd = rd;
    @(negedge usbclk);
    bus.reportPulse = 1'b0; bus.mouse_rd = 1'b0;
    if (rep) begin
      base_x = rd ? 0 : mx;
      base_y = rd ? 0 : my;
      mx = clamp16(base_x + int'($signed(dx)));
      my = clamp16(base_y + int'($signed(dy)));
      mbtn = btn[2:0];
    end else if (rd) begin
      mx = 0; my = 0;
    end
  endtask

  task automatic test_reset();
    int n;
    usbrst = 1'b1;
    bus.typ = 0; bus.reportPulse = 0; bus.conerr = 0; bus.key_modifiers = 0;
    bus.key1 = 0; bus.key2 = 0; bus.key3 = 0; bus.key4 = 0;
    bus.mouse_btn = 0; bus.mouse_dx = 0; bus.mouse_dy = 0;
    bus.evt_rd = 0; bus.ovf_clr = 0; bus.mouse_rd = 0;
    exp_q.delete(); m_ovf = 0; m_prev = 0; m_pmod = 0; mx = 0; my = 0; mbtn = 0; m_retry = 0;
    repeat (3) @(negedge usbclk);
    total++;
    if ({bus.host_rst_n, bus.link_state, bus.evt_valid, bus.evt_count, bus.evt_overflow,
         bus.mouse_x, bus.mouse_y, bus.mouse_buttons, bus.retry_cnt} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b/%0d/%0d/%0d exp=all zero",
                      bus.host_rst_n, bus.link_state, bus.evt_count, bus.retry_cnt);
    end
    usbrst = 1'b0;
    n = 0;
    while (n < 20000) begin
      @(posedge usbclk); #1; n++;
      if (bus.host_rst_n === 1'b1) break;
    end
    total++;
    if (n != RSTC) begin bad++; $display("FAIL hold_cycles got=%0d exp=%0d", n, RSTC); end
    total++;
    if (bus.link_state !== 2'd1) begin bad++; $display("FAIL wait_state got=%0d exp=1", bus.link_state); end
    @(negedge usbclk); bus.typ = 2'd1;
    @(negedge usbclk);
    total++;
    if (bus.link_state !== 2'd2) begin bad++; $display("FAIL run_state got=%0d exp=2", bus.link_state); end
  endtask

  task automatic test_kbd_basic();
    send_kbd(8'h00, 32'h0000_0004);
    send_kbd(8'h02, 32'h0000_0005);
    total++;
    if (bus.evt_count !== 5'd4) begin bad++; $display("FAIL basic_count got=%0d exp=4", bus.evt_count); end
    drain("basic");
    // Only the modifier changes, so the sole event lands on the tenth edge.
    pulse_kbd(8'h20, 32'h0000_0005);
    repeat (9) @(negedge usbclk);
    total++;
    if (bus.evt_count !== 5'd0) begin bad++; $display("FAIL latency_early got=%0d exp=0", bus.evt_count); end
    @(negedge usbclk);
    total++;
    if (bus.evt_count !== 5'd1) begin bad++; $display("FAIL latency_due got=%0d exp=1", bus.evt_count); end
    repeat (2) @(negedge usbclk);
    drain("latency");
  endtask

  task automatic test_rollover();
    send_kbd(8'h00, 32'h0000_0004);
    drain("roll_setup");
    send_kbd(8'h00, 32'h0000_0401);
    total++;
    if (bus.evt_count !== 5'd0) begin bad++; $display("FAIL rollover_count got=%0d exp=0", bus.evt_count); end
    send_kbd(8'h00, 32'h0000_0000);
    total++;
    if (bus.evt_data !== 10'h004) begin bad++; $display("FAIL rollover_release got=%h exp=004", bus.evt_data); end
    drain("rollover");
  endtask

  task automatic test_kbd_random();
    logic [31:0] keys;
    logic [7:0]  mod;
    int r;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 9);
        keys[8*i +: 8] = (r < 3) ? 8'h00 : (r == 9) ? 8'h01 : 8'(r + 1);
      end
      mod = 8'($urandom_range(0, 255)) & 8'h0a;
      send_kbd(mod, keys);
      drain("random_kbd");
    end
  endtask

  task automatic test_overflow();
    send_kbd(8'h00, 32'h0);
    drain("ovf_setup");
    send_kbd(8'h00, 32'h0706_0504);
    send_kbd(8'h00, 32'h0b0a_0908);
    send_kbd(8'h01, 32'h0706_0504);
    total++;
    if (bus.evt_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", bus.evt_count); end
    total++;
    if (bus.evt_overflow !== m_ovf) begin bad++; $display("FAIL ovf_flag got=%b exp=%b", bus.evt_overflow, m_ovf); end
    total++;
    if (bus.evt_data !== exp_q[0]) begin bad++; $display("FAIL ovf_head got=%h exp=%h", bus.evt_data, exp_q[0]); end
    bus.ovf_clr = 1'b1;
    @(negedge usbclk);
    bus.ovf_clr = 1'b0; m_ovf = 0;
    total++;
    if (bus.evt_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", bus.evt_overflow); end
    // Pop the head on the very edge the new modifier event is pushed.
    @(negedge usbclk);
    bus.key_modifiers = 8'h03; bus.reportPulse = 1'b1;
    @(negedge usbclk);
    bus.reportPulse = 1'b0;
    repeat (9) @(negedge usbclk);
    bus.evt_rd = 1'b1;
    @(negedge usbclk);
    bus.evt_rd = 1'b0;
    void'(exp_q.pop_front());
    model_report(8'h03, 32'h0706_0504);
    total++;
    if (bus.evt_count !== 5'd16 || bus.evt_overflow !== 1'b0) begin
      bad++; $display("FAIL full_pop_push got=%0d/%b exp=16/0", bus.evt_count, bus.evt_overflow);
    end
    drain("ovf_drain");
  endtask

  task automatic test_mouse();
    bit rd, rep;
    @(negedge usbclk); bus.typ = 2'd2;
    for (int n = 0; n < 40; n++) begin
      rd  = ($urandom_range(0, 3) == 0);
      rep = ($urandom_range(0, 5) != 0);
      send_mouse(8'($urandom), 8'($urandom), 8'($urandom), rd, rep);
      total++;
      if (bus.mouse_x !== 16'(mx) || bus.mouse_y !== 16'(my) || bus.mouse_buttons !== mbtn) begin
        bad++; $display("FAIL mouse_rand got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                        $signed(bus.mouse_x), $signed(bus.mouse_y), bus.mouse_buttons, mx, my, mbtn);
      end
    end
    for (int n = 0; n < 400; n++) send_mouse(8'd100, 8'hff, 8'h05, n == 0, 1);
    total++;
    if (bus.mouse_x !== 16'(mx) || bus.mouse_y !== 16'(my)) begin
      bad++; $display("FAIL mouse_sat got=%0d/%0d exp=%0d/%0d", $signed(bus.mouse_x), $signed(bus.mouse_y), mx, my);
    end
    send_mouse(8'hfb, 8'h00, 8'h02, 1, 1);
    total++;
    if (bus.mouse_x !== 16'(mx) || bus.mouse_buttons !== mbtn) begin
      bad++; $display("FAIL mouse_rd_load got=%0d exp=%0d", $signed(bus.mouse_x), mx);
    end
    @(negedge usbclk); bus.typ = 2'd1;
  endtask

  task automatic test_conerr();
    int n;
    @(negedge usbclk); bus.conerr = 1'b1;
    repeat (1000) @(negedge usbclk);
    bus.conerr = 1'b0;
    @(negedge usbclk); bus.conerr = 1'b1;
    repeat (ERRC - 1) @(negedge usbclk);
    total++;
    if (bus.link_state !== 2'd2) begin bad++; $display("FAIL conerr_early got=%0d exp=2", bus.link_state); end
    @(negedge usbclk);
    bus.conerr = 1'b0; bus.typ = 2'd0; m_retry++;
    total++;
    if (bus.link_state !== 2'd0 || bus.retry_cnt !== 8'(m_retry)) begin
      bad++; $display("FAIL conerr_trip got=%0d/%0d exp=0/%0d", bus.link_state, bus.retry_cnt, m_retry);
    end
    for (int pass = 0; pass < 2; pass++) begin
      n = 0;
      while (n < 20000) begin
        @(posedge usbclk); #1; n++;
        if (bus.host_rst_n === 1'b1) break;
      end
      total++;
      if (n != RSTC) begin bad++; $display("FAIL rehold_cycles got=%0d exp=%0d", n, RSTC); end
      if (pass == 0) begin
        n = 0;
        while (n < 10000) begin
          @(posedge usbclk); #1; n++;
          if (bus.link_state === 2'd0) break;
        end
        m_retry++;
        total++;
        if (n != TMO || bus.retry_cnt !== 8'(m_retry)) begin
          bad++; $display("FAIL wait_timeout got=%0d/%0d exp=%0d/%0d", n, bus.retry_cnt, TMO, m_retry);
        end
      end
    end
    @(negedge usbclk); bus.typ = 2'd1;
    @(negedge usbclk);
    total++;
    if (bus.link_state !== 2'd2) begin bad++; $display("FAIL rerun_state got=%0d exp=2", bus.link_state); end
  endtask

  task automatic test_disconnect();
    send_kbd(8'h00, 32'h0000_0504);
    drain("disc_setup");
    @(negedge usbclk); bus.typ = 2'd0;
    @(negedge usbclk);
    total++;
    if (bus.link_state !== 2'd1) begin bad++; $display("FAIL disc_state got=%0d exp=1", bus.link_state); end
    model_report(8'h00, 32'h0);
    repeat (12) @(negedge usbclk);
    total++;
    if (bus.evt_count !== 5'd2) begin bad++; $display("FAIL disc_count got=%0d exp=2", bus.evt_count); end
    drain("disc_flush");
  endtask

  task automatic test_reset_midflush();
    bus.typ = 2'd1;
    @(negedge usbclk);
    send_kbd(8'h00, 32'h0000_0706);
    drain("mid_setup");
    @(negedge usbclk); bus.typ = 2'd0;
    repeat (3) @(negedge usbclk);
    #2 usbrst = 1'b1;
    #1;
    total++;
    if ({bus.host_rst_n, bus.link_state, bus.evt_valid, bus.evt_count, bus.evt_overflow, bus.evt_data,
         bus.mouse_x, bus.mouse_y, bus.mouse_buttons, bus.retry_cnt} !== '0) begin
      bad++; $display("FAIL midflush_reset got=%b/%0d/%0d/%0d/%0d exp=all zero",
                      bus.host_rst_n, bus.link_state, bus.evt_count, $signed(bus.mouse_x), bus.retry_cnt);
    end
    @(negedge usbclk); usbrst = 1'b0;
    repeat (2) @(negedge usbclk);
  endtask

  initial begin
    test_reset();
    test_kbd_basic();
    test_rollover();
    test_kbd_random();
    test_overflow();
    test_mouse();
    test_conerr();
    test_disconnect();
    test_reset_midflush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
